mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Brief    : Fetch port, data port and shared memory bus of mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    logic        bus_err;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata,
               bus_err
    );

    // Requester and memory side.
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata,
               bus_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Fetch/data arbiter onto one single-port memory with timeout.
//            Define MEM_ARBITER_RR_EN for round-robin instead of data priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  wire logic    clk,
    input  wire logic    reset_n,
    mem_arbiter_if.slave bus
);
    localparam int                 c_CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LIMIT = c_CNT_W'(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_nextState;

    logic                r_we;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_ifRdata;
    logic [31:0]         r_dRdata;
    logic                r_ifAck;
    logic                r_dAck;
    logic                r_busErr;
    logic [c_CNT_W-1:0]  r_cnt;

    logic                w_dWins;
    logic                w_busy;
    logic                w_grantD;
    logic                w_grantIf;
    logic                w_timeout;
    logic                w_done;
    logic [31:0]         w_capData;

`ifdef MEM_ARBITER_RR_EN
    // Pointer says whose turn it is when both ports ask in the same IDLE cycle.
    logic r_prioD;

    assign w_dWins = bus.d_req && (!bus.if_req || r_prioD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prioD <= 1'b1;
        end else if (w_grantD) begin
            r_prioD <= 1'b0;
        end else if (w_grantIf) begin
            r_prioD <= 1'b1;
        end
    end
`else
    assign w_dWins = bus.d_req;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_busy      = (r_state != IDLE);
        w_grantD    = (r_state == IDLE) && w_dWins;
        w_grantIf   = (r_state == IDLE) && bus.if_req && !w_dWins;
        w_timeout   = w_busy && !bus.mem_ready && (r_cnt == c_CNT_LIMIT);
        w_done      = w_busy && (bus.mem_ready || w_timeout);
        w_capData   = bus.mem_ready ? bus.mem_rdata : 32'h0;
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_grantD) begin
                    w_nextState = BUSY_D;
                end else if (w_grantIf) begin
                    w_nextState = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (w_done) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we      <= 1'b0;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_ifRdata <= 32'h0;
            r_dRdata  <= 32'h0;
            r_ifAck   <= 1'b0;
            r_dAck    <= 1'b0;
            r_busErr  <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_ifAck  <= 1'b0;
            r_dAck   <= 1'b0;
            r_busErr <= 1'b0;
            if (w_grantD) begin
                r_addr  <= bus.d_addr;
                r_we    <= bus.d_we;
                r_wdata <= bus.d_wdata;
                r_cnt   <= '0;
            end else if (w_grantIf) begin
                // Fetches are reads: write data is parked at zero.
                r_addr  <= bus.if_addr;
                r_we    <= 1'b0;
                r_wdata <= 32'h0;
                r_cnt   <= '0;
            end else if (w_done) begin
                r_busErr <= w_timeout;
                if (r_state == BUSY_D) begin
                    r_dAck   <= 1'b1;
                    r_dRdata <= w_capData;
                end else begin
                    r_ifAck   <= 1'b1;
                    r_ifRdata <= w_capData;
                end
            end else if (w_busy) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    assign bus.mem_req   = w_busy;
    assign bus.mem_we    = (r_state == BUSY_D) && r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.if_rdata  = r_ifRdata;
    assign bus.if_ack    = r_ifAck;
    assign bus.d_rdata   = r_dRdata;
    assign bus.d_ack     = r_dAck;
    assign bus.bus_err   = r_busErr;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Vector table, corner sequences and random traffic for mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    localparam int TIMEOUT = 16;

    logic clk;
    logic reset_n;
    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nErrors = 0;

    // Model state: last captured data per port and round-robin turn.
    logic [31:0] mIfRdata;
    logic [31:0] mDRdata;
    bit          mPrioD;

    typedef struct {
        logic        dReq;
        logic        dWe;
        logic [31:0] dAddr;
        logic [31:0] dWdata;
        logic        ifReq;
        logic [31:0] ifAddr;
        int          delay;     // edge after grant at which mem_ready is seen, 0 = never
        logic [31:0] memData;
        logic        expD;
        logic [31:0] expAddr;
        logic        expWe;
        logic [31:0] expWdata;
        int          expAck;    // edges after grant until the ack is visible
        logic        expErr;
        logic [31:0] expRdata;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        reset_n = 1'b0;
        #1;
        chk("rst mem_req",   32'(bus.mem_req),   32'h0);
        chk("rst mem_we",    32'(bus.mem_we),    32'h0);
        chk("rst mem_addr",  bus.mem_addr,       32'h0);
        chk("rst mem_wdata", bus.mem_wdata,      32'h0);
        chk("rst if_ack",    32'(bus.if_ack),    32'h0);
        chk("rst d_ack",     32'(bus.d_ack),     32'h0);
        chk("rst bus_err",   32'(bus.bus_err),   32'h0);
        chk("rst if_rdata",  bus.if_rdata,       32'h0);
        chk("rst d_rdata",   bus.d_rdata,        32'h0);
        tick();
        reset_n  = 1'b1;
        mIfRdata = 32'h0;
        mDRdata  = 32'h0;
        mPrioD   = 1'b1;
    endtask

    // Called just after an edge in IDLE with the requests already driven.
    task automatic do_txn(input string nm, input bit eD, input int delay,
                          input logic [31:0] data, input logic [31:0] eAddr,
                          input logic eWe, input logic [31:0] eWdata,
                          input int eAck, input logic eErr, input logic [31:0] eR);
        tick();
        chk({nm, " no ack at grant"}, 32'({bus.d_ack, bus.if_ack, bus.bus_err}), 32'h0);
        for (int k = 1; k <= eAck; k++) begin
            chk({nm, " mem_req"},   32'(bus.mem_req), 32'h1);
            chk({nm, " mem_addr"},  bus.mem_addr,     eAddr);
            chk({nm, " mem_we"},    32'(bus.mem_we),  32'(eWe));
            chk({nm, " mem_wdata"}, bus.mem_wdata,    eWdata);
            bus.mem_ready = (k == delay);
            bus.mem_rdata = (k == delay) ? data : $urandom;
            tick();
            if (k < eAck) begin
                chk({nm, " early ack"}, 32'({bus.d_ack, bus.if_ack}), 32'h0);
            end
        end
        bus.mem_ready = 1'b0;
        chk({nm, " d_ack"},   32'(bus.d_ack),   32'(eD));
        chk({nm, " if_ack"},  32'(bus.if_ack),  32'(!eD));
        chk({nm, " bus_err"}, 32'(bus.bus_err), 32'(eErr));
        if (eD) begin
            mDRdata = eR;
        end else begin
            mIfRdata = eR;
        end
        chk({nm, " d_rdata"},  bus.d_rdata,  mDRdata);
        chk({nm, " if_rdata"}, bus.if_rdata, mIfRdata);
    endtask

    task automatic idle_check(input bit forceReady);
        bus.mem_ready = forceReady ? 1'b1 : 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
        tick();
        bus.mem_ready = 1'b0;
        chk("idle mem_req", 32'(bus.mem_req), 32'h0);
        chk("idle acks", 32'({bus.d_ack, bus.if_ack, bus.bus_err}), 32'h0);
        chk("idle d_rdata", bus.d_rdata, mDRdata);
        chk("idle if_rdata", bus.if_rdata, mIfRdata);
    endtask

    // Requester payloads held by the random traffic generator.
    bit          dPend, iPend, dWe;
    logic [31:0] dAddr, dWdata, iAddr;

    task automatic drive();
        bus.d_req   = dPend;
        bus.d_we    = dWe;
        bus.d_addr  = dAddr;
        bus.d_wdata = dWdata;
        bus.if_req  = iPend;
        bus.if_addr = iAddr;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h100, 32'hAAAA5555, 1'b0, 32'h0, 1, 32'hCAFEF00D,
                    1'b1, 32'h100, 1'b0, 32'hAAAA5555, 1, 1'b0, 32'hCAFEF00D};
        vecs[1] = '{1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 32'h0, 4, 32'h0BADBEEF,
                    1'b1, 32'h20, 1'b1, 32'h12345678, 4, 1'b0, 32'h0BADBEEF};
        vecs[2] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h400, 0, 32'h11111111,
                    1'b0, 32'h400, 1'b0, 32'h0, 17, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h44, 2, 32'h13579BDF,
                    1'b0, 32'h44, 1'b0, 32'h0, 2, 1'b0, 32'h13579BDF};
        vecs[4] = '{1'b1, 1'b1, 32'h8, 32'h55, 1'b1, 32'h80, 1, 32'h2468ACE0,
                    1'b1, 32'h8, 1'b1, 32'h55, 1, 1'b0, 32'h2468ACE0};
        vecs[5] = '{1'b1, 1'b0, 32'hC0, 32'h0, 1'b0, 32'h0, 18, 32'h77777777,
                    1'b1, 32'hC0, 1'b0, 32'h0, 17, 1'b1, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 32'hC4, 32'h0, 1'b0, 32'h0, 17, 32'h88888888,
                    1'b1, 32'hC4, 1'b0, 32'h0, 17, 1'b0, 32'h88888888};
        vecs[7] = '{1'b0, 1'b1, 32'hDEAD, 32'hDEADBEEF, 1'b1, 32'hFFFFFFFC, 3, 32'h600DF00D,
                    1'b0, 32'hFFFFFFFC, 1'b0, 32'h0, 3, 1'b0, 32'h600DF00D};

        reset_n = 1'b0;
        dPend = 1'b0; iPend = 1'b0; dWe = 1'b0;
        dAddr = 32'h0; dWdata = 32'h0; iAddr = 32'h0;
        drive();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        tick();

        // Single transactions from a fresh reset.
        for (int i = 0; i < 8; i++) begin
            rst_pulse();
            bus.d_req   = vecs[i].dReq;
            bus.d_we    = vecs[i].dWe;
            bus.d_addr  = vecs[i].dAddr;
            bus.d_wdata = vecs[i].dWdata;
            bus.if_req  = vecs[i].ifReq;
            bus.if_addr = vecs[i].ifAddr;
            do_txn($sformatf("vec%0d", i), vecs[i].expD, vecs[i].delay, vecs[i].memData,
                   vecs[i].expAddr, vecs[i].expWe, vecs[i].expWdata,
                   vecs[i].expAck, vecs[i].expErr, vecs[i].expRdata);
            bus.d_req  = 1'b0;
            bus.if_req = 1'b0;
        end

        // mem_ready while idle is ignored.
        for (int i = 0; i < 3; i++) idle_check(1'b1);

        // Both ports held with an immediately ready memory.
        rst_pulse();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300; bus.d_wdata = 32'h0;
        bus.if_req = 1'b1; bus.if_addr = 32'h304;
        for (int i = 0; i < 4; i++) begin
            bit eD;
`ifdef MEM_ARBITER_RR_EN
            eD = (i % 2 == 0);
`else
            eD = 1'b1;
`endif
            do_txn($sformatf("both%0d", i), eD, 1, 32'hB0B00000 + 32'(i),
                   eD ? 32'h300 : 32'h304, 1'b0, 32'h0, 1, 1'b0, 32'hB0B00000 + 32'(i));
        end
        bus.d_req = 1'b0;
        do_txn("both_if", 1'b0, 1, 32'hB0B0FFFF, 32'h304, 1'b0, 32'h0, 1, 1'b0, 32'hB0B0FFFF);
        bus.if_req = 1'b0;

        // Request dropped before grant, and payload changes after grant.
        rst_pulse();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h60; bus.d_wdata = 32'h11;
        tick();
        bus.d_addr = 32'h999; bus.d_we = 1'b1; bus.d_req = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h70;
        tick();
        chk("drop mem_addr", bus.mem_addr, 32'h60);
        chk("drop mem_we", 32'(bus.mem_we), 32'h0);
        chk("drop mem_req", 32'(bus.mem_req), 32'h1);
        bus.if_req = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h77;
        tick();
        bus.mem_ready = 1'b0;
        chk("drop d_ack", 32'(bus.d_ack), 32'h1);
        chk("drop d_rdata", bus.d_rdata, 32'h77);
        chk("drop if_ack", 32'(bus.if_ack), 32'h0);
        mDRdata = 32'h77;
        tick();
        chk("drop no grant", 32'(bus.mem_req), 32'h0);
        chk("drop acks", 32'({bus.d_ack, bus.if_ack}), 32'h0);

        // Reset in the middle of a data write.
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'h99;
        tick();
        chk("midrst busy", 32'(bus.mem_req), 32'h1);
        bus.d_req = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h500;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h5A5A5A5A;
        reset_n = 1'b0;
        #1;
        chk("midrst mem_req", 32'(bus.mem_req), 32'h0);
        chk("midrst mem_we", 32'(bus.mem_we), 32'h0);
        chk("midrst mem_addr", bus.mem_addr, 32'h0);
        chk("midrst d_rdata", bus.d_rdata, 32'h0);
        @(posedge clk);
        #1;
        chk("midrst no d_ack", 32'(bus.d_ack), 32'h0);
        bus.mem_ready = 1'b0;
        reset_n = 1'b1;
        mIfRdata = 32'h0; mDRdata = 32'h0; mPrioD = 1'b1;
        do_txn("midrst if", 1'b0, 1, 32'h5150, 32'h500, 1'b0, 32'h0, 1, 1'b0, 32'h5150);

        // Random traffic against a transaction-level model.
        rst_pulse();
        dPend = 1'b0; iPend = 1'b0;
        drive();
        for (int n = 0; n < 200; n++) begin
            bit          winD, timed;
            int          delay;
            logic [31:0] data;
            if (!dPend && $urandom_range(0, 2) != 0) begin
                dPend = 1'b1; dWe = 1'($urandom_range(0, 1));
                dAddr = $urandom; dWdata = $urandom;
            end
            if (!iPend && $urandom_range(0, 2) != 0) begin
                iPend = 1'b1; iAddr = $urandom;
            end
            drive();
            if (!dPend && !iPend) begin
                idle_check(1'b0);
                continue;
            end
`ifdef MEM_ARBITER_RR_EN
            winD = dPend && (!iPend || mPrioD);
`else
            winD = dPend;
`endif
            delay = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TIMEOUT, TIMEOUT + 3))
                                                : int'($urandom_range(1, 4));
            data  = $urandom;
            timed = (delay > TIMEOUT + 1);
            do_txn("rnd", winD, delay, data, winD ? dAddr : iAddr,
                   winD ? dWe : 1'b0, winD ? dWdata : 32'h0,
                   timed ? TIMEOUT + 1 : delay, timed, timed ? 32'h0 : data);
            if (winD) dPend = 1'b0;
            else      iPend = 1'b0;
            mPrioD = !winD;
            drive();
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule
`default_nettype wire
